// File: rtl/video_stream_tx.sv
// video_stream_tx: re-times the free-running processed pixel stream onto a
// ready/valid stream with start-of-frame (m_tuser) and end-of-line (m_tlast)
// tags. An elastic buffer plus a show-ahead output register absorbs
// downstream stalls; pixels arriving while full are dropped and flagged.
// Optional feature macro: VIDEO_STREAM_TX_FRAME_CNT_EN adds a 16-bit frame_cnt.
module video_stream_tx #(
  parameter int unsigned LINE_WIDTH   = 1920,
  parameter int unsigned FRAME_HEIGHT = 1080,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          data_valid,
  output logic [DATA_WIDTH-1:0]         m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tuser,
  output logic                          m_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow
`ifdef VIDEO_STREAM_TX_FRAME_CNT_EN
  ,
  output logic [15:0]                   frame_cnt
`endif
);

  localparam int unsigned ColW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam int unsigned RowW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
`ifdef VIDEO_STREAM_TX_FRAME_CNT_EN
  localparam int unsigned EntW = DATA_WIDTH + 3;
`else
  localparam int unsigned EntW = DATA_WIDTH + 2;
`endif
  // Entry layout: [DW-1:0] data, [DW] eol, [DW+1] sof, [DW+2] last-row tag.
  localparam int unsigned EolBit = DATA_WIDTH;
  localparam int unsigned SofBit = DATA_WIDTH + 1;

  localparam logic [ColW-1:0] ColLast = ColW'(LINE_WIDTH - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(FRAME_HEIGHT - 1);
  localparam logic [LvlW-1:0] LvlFull = LvlW'(FIFO_DEPTH);

  typedef enum logic [0:0] {StEmpty, StFull} out_state_e;

  out_state_e          state_q, state_d;
  logic [ColW-1:0]     col_q;
  logic [RowW-1:0]     row_q;
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]     level_q;
  logic                overflow_q;
  logic [EntW-1:0]     out_q, out_d;
  logic [EntW-1:0]     mem_q [FIFO_DEPTH];
  logic [EntW-1:0]     in_entry;

  logic handshake, full, push, buf_empty;
  logic load_out, load_from_buf, buf_wr, buf_rd;

  assign handshake = (state_q == StFull) && m_tready;
  assign full      = (level_q == LvlFull);
  // A pop in the same cycle frees the slot a full buffer would otherwise lack.
  assign push      = data_valid && (!full || handshake);
  // Entries waiting in the circular buffer exclude the one in the output register.
  assign buf_empty = (level_q == LvlW'(state_q == StFull));

  // Tag the incoming pixel with its frame position.
  always_comb begin
    in_entry = '0;
    in_entry[DATA_WIDTH-1:0] = data_in;
    in_entry[EolBit] = (col_q == ColLast);
    in_entry[SofBit] = (col_q == '0) && (row_q == '0);
`ifdef VIDEO_STREAM_TX_FRAME_CNT_EN
    in_entry[DATA_WIDTH+2] = (row_q == RowLast);
`endif
  end

  // Output register FSM: decide load source, buffer reads/writes and next state.
  always_comb begin
    state_d       = state_q;
    load_out      = 1'b0;
    load_from_buf = 1'b0;
    buf_wr        = 1'b0;
    buf_rd        = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (push) begin
          load_out = 1'b1;
          state_d  = StFull;
        end
      end
      StFull: begin
        if (handshake) begin
          if (!buf_empty) begin
            load_out      = 1'b1;
            load_from_buf = 1'b1;
            buf_rd        = 1'b1;
            buf_wr        = push;
          end else if (push) begin
            load_out = 1'b1;  // bypass straight from data_in
          end else begin
            state_d = StEmpty;
          end
        end else begin
          buf_wr = push;
        end
      end
      default: state_d = StEmpty;
    endcase
    out_d = load_from_buf ? mem_q[rd_ptr_q] : in_entry;
  end

  // State, pointers, level, sticky overflow and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      out_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_out) out_q <= out_d;
      if (buf_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (buf_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_q + LvlW'(push) - LvlW'(handshake);
      if (data_valid && !push) overflow_q <= 1'b1;
    end
  end

  // Frame position counters advance on every pixel, dropped or not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (data_valid) begin
      if (col_q == ColLast) begin
        col_q <= '0;
        row_q <= (row_q == RowLast) ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  // Buffer storage; contents need no reset since pointers and level do.
  always_ff @(posedge clk) begin
    if (buf_wr) mem_q[wr_ptr_q] <= in_entry;
  end

`ifdef VIDEO_STREAM_TX_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Count frames as their final pixel is handed off downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else if (handshake && out_q[EolBit] && out_q[DATA_WIDTH+2]) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign m_tvalid = (state_q == StFull);
  assign m_tdata  = out_q[DATA_WIDTH-1:0];
  assign m_tlast  = out_q[EolBit];
  assign m_tuser  = out_q[SofBit];
  assign level    = level_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_video_stream_tx.sv
// Randomized self-checking bench for video_stream_tx (LINE_WIDTH=4,
// FRAME_HEIGHT=2, FIFO_DEPTH=4) against a queue-based reference model.
module tb_video_stream_tx;

  localparam int unsigned LW = 4;
  localparam int unsigned FH = 2;
  localparam int unsigned DW = 8;
  localparam int unsigned FD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          data_valid = 1'b0;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic          m_tuser;
  logic          m_tlast;
  logic [2:0]    level;
  logic          overflow;
`ifdef VIDEO_STREAM_TX_FRAME_CNT_EN
  logic [15:0]   frame_cnt;
`endif

  video_stream_tx #(
    .LINE_WIDTH  (LW),
    .FRAME_HEIGHT(FH),
    .DATA_WIDTH  (DW),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .data_valid(data_valid),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tuser   (m_tuser),
    .m_tlast   (m_tlast),
    .level     (level),
    .overflow  (overflow)
`ifdef VIDEO_STREAM_TX_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: a pixel is {last_row, sof, eol, data}.
  typedef struct packed {
    logic          last_row;
    logic          sof;
    logic          eol;
    logic [DW-1:0] data;
  } pix_t;

  pix_t mq[$];
  int   m_idx = 0;
  logic m_ovf = 1'b0;
  int   m_fc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_idx = 0;
    m_ovf = 1'b0;
    m_fc  = 0;
  endtask

  task automatic model_edge(input logic dv, input logic [DW-1:0] d, input logic rdy);
    bit   pop, push;
    pix_t p;
    pop  = (mq.size() > 0) && rdy;
    push = dv && ((mq.size() < FD) || pop);
    if (dv && !push) m_ovf = 1'b1;
    if (pop) begin
      p = mq.pop_front();
      if (p.eol && p.last_row) m_fc = (m_fc + 1) % 65536;
    end
    if (push) begin
      p.data     = d;
      p.sof      = (m_idx == 0);
      p.eol      = (m_idx % LW) == LW - 1;
      p.last_row = (m_idx / LW) == FH - 1;
      mq.push_back(p);
    end
    if (dv) m_idx = (m_idx + 1) % (LW * FH);
  endtask

  task automatic compare_outputs();
    check_eq("tvalid", 32'(m_tvalid), 32'(mq.size() > 0));
    check_eq("level", 32'(level), 32'(mq.size()));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
    if (mq.size() > 0) begin
      check_eq("tdata", 32'(m_tdata), 32'(mq[0].data));
      check_eq("tuser", 32'(m_tuser), 32'(mq[0].sof));
      check_eq("tlast", 32'(m_tlast), 32'(mq[0].eol));
    end
`ifdef VIDEO_STREAM_TX_FRAME_CNT_EN
    check_eq("frame_cnt", 32'(frame_cnt), 32'(m_fc));
`endif
  endtask

  // One clock: drive on the falling edge, update model at the rising edge, sample 1 later.
  task automatic step(input logic dv, input logic [DW-1:0] d, input logic rdy);
    @(negedge clk);
    data_valid = dv;
    data_in    = d;
    m_tready   = rdy;
    @(posedge clk);
    model_edge(dv, d, rdy);
    #1;
    compare_outputs();
  endtask

  task automatic check_reset_zero();
    check_eq("rst_tvalid", 32'(m_tvalid), 32'd0);
    check_eq("rst_tdata", 32'(m_tdata), 32'd0);
    check_eq("rst_tuser", 32'(m_tuser), 32'd0);
    check_eq("rst_tlast", 32'(m_tlast), 32'd0);
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
`ifdef VIDEO_STREAM_TX_FRAME_CNT_EN
    check_eq("rst_frame_cnt", 32'(frame_cnt), 32'd0);
`endif
  endtask

  initial begin
    int dv_pct, rdy_pct;
    #2;
    check_reset_zero();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Pass-through: one frame at full rate.
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h10 + i), 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // Backpressure: fill, hold, then drain at full rate.
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);

    // Full with a simultaneous pop: accepted, no overflow.
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    step(1'b1, 8'h44, 1'b1);
    step(1'b1, 8'h45, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);

    // Overflow: fill, drop four, then drain and keep streaming past a frame boundary.
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h28 + i), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h60 + i), 1'b1);

    // Reset mid-frame, asserted between edges.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h50 + i), 1'b0);
    @(negedge clk);
    data_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_zero();
    model_reset();
    #1 rst_n = 1'b1;

    // Three full frames after reset, first pixel 0x55.
    for (int i = 0; i < 24; i++) step(1'b1, 8'(8'h55 + i), 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // Randomized traffic across several input/ready density mixes.
    for (int phase = 0; phase < 6; phase++) begin
      dv_pct  = 30 + 14 * phase;
      rdy_pct = 90 - 14 * phase;
      for (int i = 0; i < 300; i++) begin
        step(1'($urandom_range(99) < dv_pct), 8'($urandom), 1'($urandom_range(99) < rdy_pct));
      end
    end
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
